// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_stall_ctrl_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard inputs and stall/flush controls between the pipeline (master) and the controller (slave).
interface hazard_stall_ctrl_if;
   import hazard_stall_ctrl_pkg::*;

   logic [REG_W-1:0] ID_rs1;
   logic [REG_W-1:0] ID_rs2;
   logic             ID_EX_memread;
   logic [REG_W-1:0] ID_EX_rd;
   logic             EX_take;
   logic             EX_MEM_memaccess;
   logic             MEM_ready;

   // Memory handshake: an access in MEM completes in the cycle MEM_ready is high;
   // while EX_MEM_memaccess is high and MEM_ready is low, the pipeline holds.
   logic       PC_stall;
   logic       IF_stall;
   logic       IF_flush;
   logic       ID_bubble;
   logic       EX_stall;
   logic       MEM_stall;
   logic       mem_timeout;
   logic [7:0] wait_cnt;
   state_t     fsm_state;

   modport master (
      output ID_rs1, ID_rs2, ID_EX_memread, ID_EX_rd, EX_take, EX_MEM_memaccess, MEM_ready,
      input  PC_stall, IF_stall, IF_flush, ID_bubble, EX_stall, MEM_stall, mem_timeout,
             wait_cnt, fsm_state
   );

   modport slave (
      input  ID_rs1, ID_rs2, ID_EX_memread, ID_EX_rd, EX_take, EX_MEM_memaccess, MEM_ready,
      output PC_stall, IF_stall, IF_flush, ID_bubble, EX_stall, MEM_stall, mem_timeout,
             wait_cnt, fsm_state
   );

endinterface

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Combinational load-use hazard detection between the load in EX and the instruction in ID.
module load_use_detect
   import hazard_stall_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] ID_rs1,
   input  logic [REG_W-1:0] ID_rs2,
   input  logic             ID_EX_memread,
   input  logic [REG_W-1:0] ID_EX_rd,
   output logic             loaduse
);

   // x0 is hard-wired zero, so a load to it never creates a dependency.
   assign loaduse = ID_EX_memread && (ID_EX_rd != ZERO_REG) &&
                    ((ID_EX_rd == ID_rs1) || (ID_EX_rd == ID_rs2));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: memory-wait FSM with timeout, branch flush, load-use stall.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/bubble/flush performance counters.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   hazard_stall_ctrl_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_bubbles,
   output logic [31:0] perf_flushes
`endif
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   state_t     state;
   logic [7:0] wait_cnt;

   logic loaduse;
   logic memwait;
   logic mem_hold;
   logic timeout_hit;
   logic pc_stall, if_stall, if_flush, id_bubble, ex_stall, mem_stall, mem_timeout;

   load_use_detect u_load_use (
      .ID_rs1       (bus.ID_rs1),
      .ID_rs2       (bus.ID_rs2),
      .ID_EX_memread(bus.ID_EX_memread),
      .ID_EX_rd     (bus.ID_EX_rd),
      .loaduse      (loaduse)
   );

   assign memwait = bus.EX_MEM_memaccess && !bus.MEM_ready;

   always_comb begin
      mem_hold    = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         ST_RUN:      mem_hold = memwait;
         ST_MEM_WAIT: begin
            if (!bus.MEM_ready) begin
               if (wait_cnt >= TIMEOUT_CNT) timeout_hit = 1'b1;
               else                         mem_hold    = 1'b1;
            end
         end
         default:     mem_hold = 1'b0;
      endcase
   end

   // Release and timeout cycles carry no memory stall, so a branch frozen in EX flushes there.
   always_comb begin
      pc_stall    = 1'b0;
      if_stall    = 1'b0;
      if_flush    = 1'b0;
      id_bubble   = 1'b0;
      ex_stall    = 1'b0;
      mem_stall   = 1'b0;
      mem_timeout = 1'b0;
      if (!reset) begin
         mem_timeout = timeout_hit;
         if (mem_hold) begin
            pc_stall  = 1'b1;
            if_stall  = 1'b1;
            ex_stall  = 1'b1;
            mem_stall = 1'b1;
         end else if (bus.EX_take) begin
            if_flush  = 1'b1;
            id_bubble = 1'b1;
         end else if (loaduse) begin
            pc_stall  = 1'b1;
            if_stall  = 1'b1;
            id_bubble = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_RUN;
         wait_cnt <= 8'd0;
      end else begin
         case (state)
            ST_RUN: begin
               if (memwait) begin
                  state    <= ST_MEM_WAIT;
                  wait_cnt <= 8'd1;
               end
            end
            ST_MEM_WAIT: begin
               if (mem_hold) begin
                  wait_cnt <= wait_cnt + 8'd1;
               end else begin
                  state    <= ST_RUN;
                  wait_cnt <= 8'd0;
               end
            end
            default: begin
               state    <= ST_RUN;
               wait_cnt <= 8'd0;
            end
         endcase
      end
   end

   assign bus.PC_stall    = pc_stall;
   assign bus.IF_stall    = if_stall;
   assign bus.IF_flush    = if_flush;
   assign bus.ID_bubble   = id_bubble;
   assign bus.EX_stall    = ex_stall;
   assign bus.MEM_stall   = mem_stall;
   assign bus.mem_timeout = mem_timeout;
   assign bus.wait_cnt    = wait_cnt;
   assign bus.fsm_state   = state;

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stall_cycles <= 32'd0;
         perf_bubbles      <= 32'd0;
         perf_flushes      <= 32'd0;
      end else begin
         if (pc_stall && (perf_stall_cycles != 32'hFFFF_FFFF))
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (id_bubble && (perf_bubbles != 32'hFFFF_FFFF))
            perf_bubbles <= perf_bubbles + 32'd1;
         if (if_flush && (perf_flushes != 32'hFFFF_FFFF))
            perf_flushes <= perf_flushes + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed hazard scenarios plus randomized traffic.
module tb_hazard_stall_ctrl;
   import hazard_stall_ctrl_pkg::*;

   localparam int T = 16;
   localparam int W = 16;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   hazard_stall_ctrl_if bus ();

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_cycles, perf_bubbles, perf_flushes;
`endif

   hazard_stall_ctrl #(.MEM_TIMEOUT(T)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .perf_stall_cycles(perf_stall_cycles),
      .perf_bubbles     (perf_bubbles),
      .perf_flushes     (perf_flushes)
`endif
   );

   always #5 clk = ~clk;

   // Observed vector: {in_wait, PC, IF, flush, bubble, EX, MEM, timeout, wait_cnt}
   logic [W-1:0] dut_vec;
   assign dut_vec = {bus.fsm_state == ST_MEM_WAIT, bus.PC_stall, bus.IF_stall, bus.IF_flush,
                     bus.ID_bubble, bus.EX_stall, bus.MEM_stall, bus.mem_timeout, bus.wait_cnt};

   logic [W-1:0] exp_q[$];
   int stall_run = 0;  // consecutive memory-stall cycles seen so far

   function automatic logic [W-1:0] model(input bit rst, input bit ma, input bit rdy,
                                          input bit tk, input bit mr, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input int run, output int nxt);
      bit lu, hold, to, pc, ifs, fl, bub, ex, mem;
      lu   = mr && (rd != 0) && (rd == rs1 || rd == rs2);
      hold = 0;
      to   = 0;
      if (run == 0)     hold = ma && !rdy;
      else if (!rdy) begin
         if (run < T) hold = 1;
         else         to = 1;
      end
      nxt = (hold && !rst) ? run + 1 : 0;
      pc = hold || (!tk && lu);
      ifs = pc;
      fl = !hold && tk;
      bub = !hold && (tk || lu);
      ex = hold;
      mem = hold;
      if (rst) begin
         pc = 0; ifs = 0; fl = 0; bub = 0; ex = 0; mem = 0; to = 0;
      end
      return {run != 0, pc, ifs, fl, bub, ex, mem, to, 8'(run)};
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [W-1:0] e;
         e = exp_q.pop_front();
         checks++;
         if (dut_vec !== e) begin
            failures++;
            $display("FAIL cycle_check t=%0t got=%h exp=%h", $time, dut_vec, e);
         end
      end
   end

   task automatic drive(input bit rst, input bit ma, input bit rdy, input bit tk, input bit mr,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit has_lit, input logic [W-1:0] lit, input string name);
      logic [W-1:0] e;
      int nxt;
      reset = rst;
      bus.EX_MEM_memaccess = ma;
      bus.MEM_ready = rdy;
      bus.EX_take = tk;
      bus.ID_EX_memread = mr;
      bus.ID_EX_rd = rd;
      bus.ID_rs1 = rs1;
      bus.ID_rs2 = rs2;
      e = model(rst, ma, rdy, tk, mr, rd, rs1, rs2, stall_run, nxt);
      exp_q.push_back(e);
      @(negedge clk);
      if (has_lit) begin
         checks += 2;
         if (e !== lit) begin
            failures++;
            $display("FAIL model_pin_%s model=%h required=%h", name, e, lit);
         end
         if (dut_vec !== lit) begin
            failures++;
            $display("FAIL lit_%s got=%h required=%h", name, dut_vec, lit);
         end
      end
      @(posedge clk);
      stall_run = nxt;
      #1;
   endtask

   task automatic idle(input bit has_lit, input logic [W-1:0] lit, input string name);
      drive(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, has_lit, lit, name);
   endtask

   initial begin
      reset = 1'b1;
      bus.EX_MEM_memaccess = 0; bus.MEM_ready = 1; bus.EX_take = 0;
      bus.ID_EX_memread = 0; bus.ID_EX_rd = 0; bus.ID_rs1 = 0; bus.ID_rs2 = 0;
      @(posedge clk); #1;
      drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 16'h0000, "reset");

      // Load-use on rs2, then the bubble clears it.
      drive(0, 0, 1, 0, 1, 5'd5, 5'd1, 5'd5, 1, 16'h6800, "loaduse");
      idle(1, 16'h0000, "loaduse_clear");
      drive(0, 0, 1, 0, 1, 5'd0, 5'd0, 5'd0, 1, 16'h0000, "loaduse_x0");

      // Taken branch overrides concurrent load-use on rs1.
      drive(0, 0, 1, 1, 1, 5'd7, 5'd7, 5'd2, 1, 16'h1800, "branch");

      // Three-cycle memory wait then completion.
      drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 16'h6600, "mw1");
      drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 16'hE601, "mw2");
      drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 16'hE602, "mw3");
      drive(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 16'h8003, "mw_release");
      idle(1, 16'h0000, "mw_after");

      // Timeout: 16 stalled cycles, forced release, then re-stall.
      for (int i = 0; i < T; i++)
         drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, '0, "");
      drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 16'h8110, "timeout");
      drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 16'h6600, "restall");
      drive(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 16'h8001, "restall_release");

      // Reset in the middle of a wait at wait_cnt = 7.
      for (int i = 0; i < 7; i++)
         drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, '0, "");
      drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 16'h8007, "reset_mid");
      idle(1, 16'h0000, "after_reset_mid");

      // Branch frozen during a wait flushes in the release cycle.
      drive(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1, 16'h6600, "br_wait1");
      drive(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1, 16'hE601, "br_wait2");
      drive(0, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 1, 16'h9802, "br_release");
      idle(0, '0, "");

`ifdef HAZARD_PERF_CNT_EN
      drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, '0, "");
      for (int i = 0; i < 3; i++)
         drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, '0, "");
      drive(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, '0, "");
      drive(0, 0, 1, 0, 1, 5'd5, 5'd0, 5'd5, 0, '0, "");
      checks += 3;
      if (perf_stall_cycles !== 32'd4) begin
         failures++;
         $display("FAIL perf_stall got=%0d required=4", perf_stall_cycles);
      end
      if (perf_bubbles !== 32'd1) begin
         failures++;
         $display("FAIL perf_bubbles got=%0d required=1", perf_bubbles);
      end
      if (perf_flushes !== 32'd0) begin
         failures++;
         $display("FAIL perf_flushes got=%0d required=0", perf_flushes);
      end
`endif

      // Randomized traffic with small register numbers to provoke collisions.
      for (int i = 0; i < 1500; i++) begin
         drive($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 0, '0, "");
      end

      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain got=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller for the five-stage core. It drives the stall and bubble/flush controls of the PC, IF/ID, ID/EX and EX/MEM registers, including the `EX_stall` hold input of the ID/EX register. It detects load-use hazards and taken branches/jumps resolved in EX. It also runs a wait-state FSM with timeout for the data-memory ready handshake.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 16: maximum number of consecutive memory-wait stall cycles before forced release; legal range 1..255.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ID_rs1`  in  5  source register 1 of the instruction in ID.
- `ID_rs2`  in  5  source register 2 of the instruction in ID.
- `ID_EX_memread`  in  1  the instruction in EX is a load.
- `ID_EX_rd`  in  5  destination register of the instruction in EX.
- `EX_take`  in  1  branch taken or unconditional jump resolved in EX.
- `EX_MEM_memaccess`  in  1  the instruction in MEM is a load or store.
- `MEM_ready`  in  1  data memory completes the access this cycle.
- `PC_stall`  out  1  hold the PC.
- `IF_stall`  out  1  hold the IF/ID register.
- `IF_flush`  out  1  zero the IF/ID register (insert NOP).
- `ID_bubble`  out  1  load zero control signals into ID/EX.
- `EX_stall`  out  1  hold ID/EX.
- `MEM_stall`  out  1  hold EX/MEM.
- `mem_timeout`  out  1  one-cycle pulse on forced release.
- `wait_cnt`  out  8  current memory-wait count.

## Operation
- FSM has two states: `RUN` and `MEM_WAIT`. Reset state is `RUN`; `wait_cnt` resets to 0.
- While `reset` is high, all stall, flush and bubble outputs and `mem_timeout` are forced to 0.
- Condition terms:
  - `memwait` = `EX_MEM_memaccess & !MEM_ready`.
  - `loaduse` = `ID_EX_memread & ID_EX_rd != 0 & (ID_EX_rd == ID_rs1 | ID_EX_rd == ID_rs2)`.
- Priority is memory wait, then branch flush, then load-use.
- Memory wait:
  - In `RUN` with `memwait`, assert `PC_stall`, `IF_stall`, `EX_stall` and `MEM_stall`. The next state is `MEM_WAIT` and `wait_cnt` becomes 1.
  - In `MEM_WAIT` with `MEM_ready`, deassert all stalls in the same cycle. The next state is `RUN` and `wait_cnt` becomes 0.
  - In `MEM_WAIT` with `!MEM_ready` and `wait_cnt < MEM_TIMEOUT`, keep all stalls asserted and increment `wait_cnt`.
  - In `MEM_WAIT` with `!MEM_ready` and `wait_cnt == MEM_TIMEOUT`, drive `mem_timeout` = 1 and all stalls 0. The next state is `RUN` and `wait_cnt` becomes 0.
- Branch flush, when there is no memory stall and `EX_take` = 1: drive `IF_flush` = 1 and `ID_bubble` = 1. `PC_stall` stays 0 so the PC loads the target. Any load-use term is ignored that cycle.
- Load-use, when there is no memory stall and no `EX_take`: drive `PC_stall` = 1, `IF_stall` = 1 and `ID_bubble` = 1. `EX_stall` stays 0. The hazard clears naturally next cycle because the bubble carries `memread` = 0.
- `ID_bubble` and `EX_stall` are never both 1.
- A taken branch during a memory wait is frozen in EX. Its flush is applied in the release cycle only if `EX_take` is still high then.

## Timing
- All outputs are combinational from the current state and inputs. State and `wait_cnt` are registered.
- A memory stall asserts in the same cycle `memwait` first rises (zero latency).
- Maximum memory stall length is `MEM_TIMEOUT` cycles. The forced-release cycle has no stall asserted.
- A fresh `memwait` in the cycle after a release re-enters `MEM_WAIT` normally.
- Reset mid-wait: outputs drop to 0 in the reset cycle. After the edge the state is `RUN` and `wait_cnt` is 0. No `mem_timeout` pulse is produced.

## Configuration
- `HAZARD_PERF_CNT_EN` defined adds three 32-bit outputs:
  - `perf_stall_cycles`: cycles with `PC_stall` = 1.
  - `perf_bubbles`: cycles with `ID_bubble` = 1.
  - `perf_flushes`: cycles with `IF_flush` = 1.
- The counters reset to 0, saturate at 0xFFFFFFFF, and update on the clock edge.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package holds:
  - the state encoding constants `ST_RUN` = 1'b0 and `ST_MEM_WAIT` = 1'b1;
  - `REG_W` = 5 and `ZERO_REG` = 5'd0.
- Sub-module `load_use_detect` is purely combinational and takes `ID_rs1`, `ID_rs2`, `ID_EX_memread` and `ID_EX_rd`, producing `loaduse`.
- The FSM, the counter and the output decode live in the top module.

## Test plan
- Load-use: `ID_EX_memread` = 1, `ID_EX_rd` = 5, `ID_rs2` = 5 -> `PC_stall`, `IF_stall`, `ID_bubble` = 1 for one cycle; `EX_stall` = 0. Repeat with `rd` = 0 -> no stall.
- Branch: `EX_take` = 1 with a concurrent load-use on `rs1` -> `IF_flush` = `ID_bubble` = 1 and `PC_stall` = 0.
- Memory wait: `EX_MEM_memaccess` = 1, `MEM_ready` = 0 for 3 cycles then 1 -> all four stalls high for 3 cycles and low in the 4th; `wait_cnt` runs 0,1,2,3 then 0.
- Timeout: `MEM_TIMEOUT` = 16, `MEM_ready` held 0 -> 16 stalled cycles, then one cycle with `mem_timeout` = 1 and stalls = 0, then re-stall.
- Reset at `wait_cnt` = 7 -> outputs 0 during reset, then `RUN` with `wait_cnt` = 0 and no timeout pulse.
- With `HAZARD_PERF_CNT_EN`: 3-cycle memory wait plus one load-use -> `perf_stall_cycles` = 4, `perf_bubbles` = 1, `perf_flushes` = 0.
